// File: rtl/key_pkg.sv
// Shared types and defaults for the key event classifier.
package key_pkg;

  localparam int CNT_W             = 21;
  localparam int LONG_CYCLES_DEF   = 50;
  localparam int REPEAT_CYCLES_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/key_event_if.sv
// Key level in, classified one-cycle events and held level out.
interface key_event_if;

  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  // master drives the debounced key and consumes the events
  modport master (
    output key_level,
    input  press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    input  key_level,
    output press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
  );

endinterface

// File: rtl/key_event.sv
// Classifies a debounced key level into press / release / click / long / repeat events.
module key_event
  import key_pkg::*;
#(
  parameter int LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic      clk,
  input  logic      nrst,
  key_event_if.slave ev
);

  localparam cnt_t LONG_LAST   = cnt_t'(LONG_CYCLES - 1);
  localparam cnt_t REPEAT_LAST = cnt_t'(REPEAT_CYCLES - 1);

  state_t state;
  cnt_t   cnt;
  logic   press_q;
  logic   release_q;
  logic   click_q;
  logic   long_q;
  logic   repeat_q;
  logic   held_q;

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments; pulses default low so
    // each one lasts exactly the cycle after the edge that raised it.
    press_q   <= 1'b0;
    release_q <= 1'b0;
    click_q   <= 1'b0;
    long_q    <= 1'b0;
    repeat_q  <= 1'b0;

    if (nrst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      held_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (ev.key_level) begin
            state   <= ST_PRESSED;
            press_q <= 1'b1;
            held_q  <= 1'b1;
          end else begin
            held_q  <= 1'b0;
          end
        end

        // release is tested first so it wins over a threshold on the same edge
        ST_PRESSED: begin
          if (!ev.key_level) begin
            state     <= ST_IDLE;
            release_q <= 1'b1;
            click_q   <= 1'b1;
            held_q    <= 1'b0;
            cnt       <= '0;
          end else if (cnt == LONG_LAST) begin
            state  <= ST_LONG;
            long_q <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // with repeats disabled the counter still restarts so it never wraps
        ST_LONG: begin
          if (!ev.key_level) begin
            state     <= ST_IDLE;
            release_q <= 1'b1;
            held_q    <= 1'b0;
            cnt       <= '0;
          end else if (cnt == REPEAT_LAST) begin
            repeat_q <= REPEAT_EN;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          held_q <= 1'b0;
        end
      endcase
    end
  end

  assign ev.press_pulse   = press_q;
  assign ev.release_pulse = release_q;
  assign ev.click_pulse   = click_q;
  assign ev.long_pulse    = long_q;
  assign ev.repeat_pulse  = repeat_q;
  assign ev.held          = held_q;

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: default DUT (repeats on) and a REPEAT_EN=0 DUT.
module tb_key_event;

  logic clk  = 1'b0;
  logic nrst = 1'b1;

  key_event_if ifa ();
  key_event_if ifb ();

  key_event #(.LONG_CYCLES(50), .REPEAT_CYCLES(10), .REPEAT_EN(1'b1)) dut_a (
    .clk  (clk),
    .nrst (nrst),
    .ev   (ifa.slave)
  );

  key_event #(.LONG_CYCLES(50), .REPEAT_CYCLES(10), .REPEAT_EN(1'b0)) dut_b (
    .clk  (clk),
    .nrst (nrst),
    .ev   (ifb.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int press_n;
    int release_n;
    int click_n;
    int long_n;
    int rep_n;
    int held_n;
    int multi_n;
    int press_e;
    int release_e;
    int long_e;
    int rep_e0;
    int rep_e1;
  } stats_t;

  stats_t st [2];
  int     edge_n;
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    edge_n = 0;
    for (int i = 0; i < 2; i++) begin
      st[i] = '{default: 0};
      st[i].press_e   = -1;
      st[i].release_e = -1;
      st[i].long_e    = -1;
      st[i].rep_e0    = -1;
      st[i].rep_e1    = -1;
    end
  endtask

  task automatic sample_one(input int idx, input logic p, input logic r, input logic c,
                            input logic l, input logic rp, input logic h);
    if (p)  begin st[idx].press_n++;   st[idx].press_e   = edge_n; end
    if (r)  begin st[idx].release_n++; st[idx].release_e = edge_n; end
    if (c)  st[idx].click_n++;
    if (l)  begin st[idx].long_n++;    st[idx].long_e    = edge_n; end
    if (rp) begin
      if (st[idx].rep_n == 0) st[idx].rep_e0 = edge_n;
      if (st[idx].rep_n == 1) st[idx].rep_e1 = edge_n;
      st[idx].rep_n++;
    end
    if (h)  st[idx].held_n++;
    // only release+click may coincide; click alone is also illegal
    if ((int'(p) + int'(r) + int'(l) + int'(rp)) > 1 || (c && !r)) st[idx].multi_n++;
  endtask

  // one clock edge, then sample both DUTs 1ns later
  task automatic step();
    @(posedge clk);
    edge_n++;
    #1;
    sample_one(0, ifa.press_pulse, ifa.release_pulse, ifa.click_pulse,
               ifa.long_pulse, ifa.repeat_pulse, ifa.held);
    sample_one(1, ifb.press_pulse, ifb.release_pulse, ifb.click_pulse,
               ifb.long_pulse, ifb.repeat_pulse, ifb.held);
  endtask

  task automatic hold_a(input int n, input int tail);
    ifa.key_level = 1'b1;
    repeat (n) step();
    ifa.key_level = 1'b0;
    repeat (tail) step();
  endtask

  function automatic int outs_a();
    return int'({ifa.press_pulse, ifa.release_pulse, ifa.click_pulse,
                 ifa.long_pulse, ifa.repeat_pulse, ifa.held});
  endfunction

  function automatic int outs_b();
    return int'({ifb.press_pulse, ifb.release_pulse, ifb.click_pulse,
                 ifb.long_pulse, ifb.repeat_pulse, ifb.held});
  endfunction

  initial begin
    ifa.key_level = 1'b0;
    ifb.key_level = 1'b0;
    clear_stats();

    // reset with a key pressed must still keep everything quiet
    ifa.key_level = 1'b1;
    repeat (3) step();
    check("reset_outs_a", outs_a(), 0);
    check("reset_outs_b", outs_b(), 0);
    ifa.key_level = 1'b0;
    nrst = 1'b0;
    repeat (2) step();

    // short press: 20 cycles high
    clear_stats();
    hold_a(20, 4);
    check("short_press_n",   st[0].press_n,   1);
    check("short_press_e",   st[0].press_e,   1);
    check("short_release_e", st[0].release_e, 21);
    check("short_click_n",   st[0].click_n,   1);
    check("short_long_n",    st[0].long_n,    0);
    check("short_held_n",    st[0].held_n,    20);
    check("short_multi",     st[0].multi_n,   0);

    // long hold 75 cycles: long at +50, repeats at +60/+70
    clear_stats();
    hold_a(75, 4);
    check("long_press_e",   st[0].press_e,   1);
    check("long_long_n",    st[0].long_n,    1);
    check("long_long_e",    st[0].long_e,    51);
    check("long_rep_n",     st[0].rep_n,     2);
    check("long_rep_e0",    st[0].rep_e0,    61);
    check("long_rep_e1",    st[0].rep_e1,    71);
    check("long_release_e", st[0].release_e, 76);
    check("long_release_n", st[0].release_n, 1);
    check("long_click_n",   st[0].click_n,   0);
    check("long_held_n",    st[0].held_n,    75);
    check("long_multi",     st[0].multi_n,   0);

    // 49 cycles high: released one edge before threshold
    clear_stats();
    hold_a(49, 4);
    check("b49_release_e", st[0].release_e, 50);
    check("b49_click_n",   st[0].click_n,   1);
    check("b49_long_n",    st[0].long_n,    0);

    // 50 cycles high: release lands on the threshold edge and must win
    clear_stats();
    hold_a(50, 4);
    check("b50_release_e", st[0].release_e, 51);
    check("b50_click_n",   st[0].click_n,   1);
    check("b50_long_n",    st[0].long_n,    0);
    check("b50_multi",     st[0].multi_n,   0);

    // reset pulse while in LONG with the key still down
    clear_stats();
    ifa.key_level = 1'b1;
    repeat (60) step();
    check("rst_in_long_n", st[0].long_n, 1);
    nrst = 1'b1;
    step();
    check("rst_mid_outs", outs_a(), 0);
    nrst = 1'b0;
    step();
    check("rst_repress_e",  st[0].press_e,   62);
    check("rst_press_n",    st[0].press_n,   2);
    check("rst_no_release", st[0].release_n, 0);
    ifa.key_level = 1'b0;
    repeat (3) step();
    check("rst_release_e",  st[0].release_e, 63);
    check("rst_click_n",    st[0].click_n,   1);

    // single-cycle key high
    clear_stats();
    hold_a(1, 3);
    check("blip_press_e",   st[0].press_e,   1);
    check("blip_release_e", st[0].release_e, 2);
    check("blip_click_n",   st[0].click_n,   1);
    check("blip_held_n",    st[0].held_n,    1);
    check("blip_multi",     st[0].multi_n,   0);

    // repeats disabled: 100-cycle hold gives long_pulse only
    clear_stats();
    ifb.key_level = 1'b1;
    repeat (100) step();
    ifb.key_level = 1'b0;
    repeat (4) step();
    check("norep_long_n",    st[1].long_n,    1);
    check("norep_long_e",    st[1].long_e,    51);
    check("norep_rep_n",     st[1].rep_n,     0);
    check("norep_release_e", st[1].release_e, 101);
    check("norep_click_n",   st[1].click_n,   0);
    check("norep_a_quiet",   st[0].press_n,   0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
